alu_pipe_mul: RTL and testbench

// Parametrised, handshaked successor to the 16-bit single-cycle ALU. One operation is issued per valid/ready

---
 rtl/alu_pipe_mul.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_pipe_mul.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mul.sv
// Handshaked ALU with full/half width single-cycle ops, a shift-add multiplier and
// a registered result/flag stage. Flags are {Z,C,N,O}.
module alu_pipe_mul #(
    parameter int unsigned W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [4:0]   FunSel,
    input  logic         MulEn,
    input  logic         WF,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] ALUOut,
    output logic [3:0]   FlagsOut
);

    localparam int unsigned H    = W / 2;
    localparam int unsigned CntW = $clog2(W);

    localparam logic [W-1:0] MaskHalf = {{(W - H){1'b0}}, {H{1'b1}}};
    localparam logic [W-1:0] TopFull  = {1'b1, {(W - 1){1'b0}}};
    localparam logic [W-1:0] TopHalf  = {{(W - H){1'b0}}, 1'b1, {(H - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [2*W-1:0]      acc_q;
    logic [2*W-1:0]      mcand_q;
    logic [W-1:0]        mplier_q;
    logic                full_q;
    logic                wf_q;
    logic                out_valid_q;
    logic [W-1:0]        alu_out_q;
    logic [3:0]          flags_q;

    logic                accept;
    logic                full;
    logic [W-1:0]        mask;
    logic [W-1:0]        top;
    logic [W-1:0]        a_m;
    logic [W-1:0]        b_m;
    logic [3:0]          op;

    assign full     = FunSel[4];
    assign op       = FunSel[3:0];
    assign mask     = full ? {W{1'b1}} : MaskHalf;
    assign top      = full ? TopFull : TopHalf;
    assign a_m      = A & mask;
    assign b_m      = B & mask;

    assign InReady  = Reset & (state_q == StIdle) & (~out_valid_q | OutReady);
    assign accept   = InValid & InReady;
    assign OutValid = out_valid_q;
    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;

    // Single-cycle datapath
    logic          cin;
    logic          a_msb;
    logic          b_msb;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W:0]    sum;
    logic [W-1:0]  add_r;
    logic          add_c;
    logic          add_r_msb;
    logic          add_o;
    logic [W-1:0]  shl;
    logic [W-1:0]  shr;
    logic [W-1:0]  res;
    logic          c_new;
    logic          wr_c;
    logic          wr_o;
    logic          wr_n;
    logic [3:0]    single_flags;

    always_comb begin
        cin       = flags_q[2];
        a_msb     = |(a_m & top);
        b_msb     = |(b_m & top);
        add_b     = (op == 4'h6) ? (~b_m & mask) : b_m;
        add_cin   = (op == 4'h6) ? 1'b1 : ((op == 4'h5) ? cin : 1'b0);
        sum       = {1'b0, a_m} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        add_r     = sum[W-1:0] & mask;
        add_c     = full ? sum[W] : sum[H];
        add_r_msb = |(add_r & top);
        add_o     = (op == 4'h6) ? ((a_msb != b_msb) & (add_r_msb != a_msb))
                                 : ((a_msb == b_msb) & (add_r_msb != a_msb));
        shl       = (a_m << 1) & mask;
        shr       = a_m >> 1;

        res   = '0;
        c_new = cin;
        wr_c  = 1'b0;
        wr_o  = 1'b0;
        wr_n  = 1'b1;
        unique case (op)
            4'h0: res = a_m;
            4'h1: res = b_m;
            4'h2: res = ~a_m & mask;
            4'h3: res = ~b_m & mask;
            4'h4, 4'h5, 4'h6: begin
                res   = add_r;
                c_new = add_c;
                wr_c  = 1'b1;
                wr_o  = 1'b1;
            end
            4'h7: res = a_m & b_m;
            4'h8: res = a_m | b_m;
            4'h9: res = a_m ^ b_m;
            4'hA: res = ~(a_m & b_m) & mask;
            4'hB: begin
                res   = shl;
                c_new = a_msb;
                wr_c  = 1'b1;
            end
            4'hC: begin
                res   = shr;
                c_new = a_m[0];
                wr_c  = 1'b1;
            end
            4'hD: begin
                res   = shr | (a_msb ? top : '0);
                c_new = a_m[0];
                wr_c  = 1'b1;
                wr_n  = 1'b0;
            end
            4'hE: begin
                res   = shl | {{(W - 1){1'b0}}, cin};
                c_new = a_msb;
                wr_c  = 1'b1;
            end
            4'hF: begin
                res   = shr | (cin ? top : '0);
                c_new = a_m[0];
                wr_c  = 1'b1;
            end
            default: res = '0;
        endcase

        single_flags = {res == '0,
                        wr_c ? c_new : flags_q[2],
                        wr_n ? |(res & top) : flags_q[1],
                        wr_o ? add_o : flags_q[0]};
    end

    // Multiplier: the final iteration's sum is captured directly, so the result
    // lands on the Nth edge after accept.
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mul_lo;
    logic           mul_hi_nz;
    logic [3:0]     mul_flags;
    logic           mul_last;
    logic           mul_done;

    always_comb begin
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_lo    = full_q ? acc_next[W-1:0] : {{(W - H){1'b0}}, acc_next[H-1:0]};
        mul_hi_nz = full_q ? |acc_next[2*W-1:W] : |acc_next[W-1:H];
        mul_flags = {mul_lo == '0, mul_hi_nz,
                     |(mul_lo & (full_q ? TopFull : TopHalf)), flags_q[0]};
        mul_last  = full_q ? (cnt_q == CntW'(W - 1)) : (cnt_q == CntW'(H - 1));
    end

    always_comb begin
        state_d  = state_q;
        mul_done = 1'b0;
        unique case (state_q)
            StIdle: if (accept && MulEn) state_d = StMul;
            StMul: begin
                if (mul_last) begin
                    state_d  = StIdle;
                    mul_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            full_q      <= 1'b0;
            wf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
        end else begin
            state_q <= state_d;

            if (accept && MulEn) begin
                full_q   <= full;
                wf_q     <= WF;
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= {{W{1'b0}}, a_m};
                mplier_q <= b_m;
            end else if (state_q == StMul) begin
                cnt_q    <= cnt_q + CntW'(1);
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end

            if (accept && !MulEn) begin
                out_valid_q <= 1'b1;
                alu_out_q   <= res;
                if (WF) flags_q <= single_flags;
            end else if (mul_done) begin
                out_valid_q <= 1'b1;
                alu_out_q   <= mul_lo;
                if (wf_q) flags_q <= mul_flags;
            end else if (OutReady) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_mul.sv
// Bench for alu_pipe_mul: directed cases with literal expectations, then random
// traffic checked every cycle against an arithmetic model of the op set.
module tb_alu_pipe_mul;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [4:0]   FunSel = '0;
    logic         MulEn = 1'b0;
    logic         WF = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [W-1:0] ALUOut;
    logic [3:0]   FlagsOut;

    alu_pipe_mul #(.W(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .MulEn    (MulEn),
        .WF       (WF),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Model state
    bit           have_out = 0;
    logic [W-1:0] exp_out = '0;
    logic [3:0]   flags_vis = '0;
    int           busy = 0;
    logic [W-1:0] pend_out = '0;
    logic [3:0]   pend_flags = '0;
    bit           pend_wf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit msb_of(input longint v, input int n);
        return ((v >> (n - 1)) & 1) != 0;
    endfunction

    function automatic void model_op(input logic [3:0] op, input bit full, input bit mul,
                                     input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                     input logic [3:0] fl, output logic [W-1:0] r_out,
                                     output logic [3:0] nf);
        int     n;
        longint mask, a, b, r, p;
        bit     c, o, nn, cin, amsb, bmsb, wn;
        n    = full ? W : W / 2;
        mask = (longint'(1) << n) - 1;
        a    = longint'(a_in) & mask;
        b    = longint'(b_in) & mask;
        cin  = fl[2];
        c    = fl[2];
        nn   = fl[1];
        o    = fl[0];
        wn   = 1;
        amsb = msb_of(a, n);
        bmsb = msb_of(b, n);
        r    = 0;
        if (mul) begin
            p = a * b;
            r = p & mask;
            c = (p >> n) != 0;
        end else begin
            case (op)
                4'h0: r = a;
                4'h1: r = b;
                4'h2: r = ~a & mask;
                4'h3: r = ~b & mask;
                4'h4, 4'h5: begin
                    r = a + b + ((op == 4'h5) ? longint'(cin) : 0);
                    c = ((r >> n) & 1) != 0;
                    r = r & mask;
                    o = (amsb == bmsb) && (msb_of(r, n) != amsb);
                end
                4'h6: begin
                    r = a + (~b & mask) + 1;
                    c = ((r >> n) & 1) != 0;
                    r = r & mask;
                    o = (amsb != bmsb) && (msb_of(r, n) != amsb);
                end
                4'h7: r = a & b;
                4'h8: r = a | b;
                4'h9: r = a ^ b;
                4'hA: r = ~(a & b) & mask;
                4'hB: begin r = (a << 1) & mask; c = amsb; end
                4'hC: begin r = a >> 1; c = (a & 1) != 0; end
                4'hD: begin
                    r  = (a >> 1) | (longint'(amsb) << (n - 1));
                    c  = (a & 1) != 0;
                    wn = 0;
                end
                4'hE: begin r = ((a << 1) | longint'(cin)) & mask; c = amsb; end
                default: begin
                    r = (a >> 1) | (longint'(cin) << (n - 1));
                    c = (a & 1) != 0;
                end
            endcase
        end
        if (wn) nn = msb_of(r, n);
        r_out = r[W-1:0];
        nf    = {r == 0, c, nn, o};
    endfunction

    // One clock: drive at negedge, check handshake, advance model, check outputs after posedge.
    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] fs, input bit mul, input bit wf, input bit ordy);
        bit           exp_ready;
        logic [W-1:0] r;
        logic [3:0]   f;
        @(negedge Clock);
        InValid  = v;
        A        = a;
        B        = b;
        FunSel   = fs;
        MulEn    = mul;
        WF       = wf;
        OutReady = ordy;
        #1;
        exp_ready = Reset && (busy == 0) && (!have_out || ordy);
        check("in_ready", InReady, exp_ready);
        if (Reset) begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    have_out = 1;
                    exp_out  = pend_out;
                    if (pend_wf) flags_vis = pend_flags;
                end
            end else if (have_out && ordy) begin
                have_out = 0;
            end
            if (v && exp_ready) begin
                model_op(fs[3:0], fs[4], mul, a, b, flags_vis, r, f);
                if (mul) begin
                    busy       = fs[4] ? W : W / 2;
                    pend_out   = r;
                    pend_flags = f;
                    pend_wf    = wf;
                end else begin
                    have_out = 1;
                    exp_out  = r;
                    if (wf) flags_vis = f;
                end
            end
        end
        @(posedge Clock);
        #1;
        check("out_valid", OutValid, have_out);
        if (have_out) check("alu_out", ALUOut, exp_out);
        check("flags", FlagsOut, flags_vis);
    endtask

    task automatic idle(input bit ordy);
        step(0, '0, '0, 5'b0, 0, 0, ordy);
    endtask

    int mul_cycles;

    initial begin
        // Reset state
        InValid = 1'b1;
        repeat (2) @(negedge Clock);
        check("rst_out_valid", OutValid, 0);
        check("rst_alu_out", ALUOut, 0);
        check("rst_flags", FlagsOut, 0);
        check("rst_in_ready", InReady, 0);
        InValid = 1'b0;
        Reset   = 1'b1;

        step(1, 16'h7FFF, 16'h0001, 5'b10100, 0, 1, 1);
        check("add_full_out", ALUOut, 16'h8000);
        check("add_full_flags", FlagsOut, 4'b0011);

        step(1, 16'h0012, 16'h0034, 5'b00110, 0, 1, 1);
        check("sub_half_out", ALUOut, 16'h00DE);
        check("sub_half_flags", FlagsOut, 4'b0010);

        step(1, 16'h0000, 16'h0000, 5'b00101, 0, 1, 1);
        check("adc_half_out", ALUOut, 16'h0000);
        check("adc_half_flags", FlagsOut, 4'b1000);

        step(1, 16'h0100, 16'h0100, 5'b10000, 1, 1, 1);
        mul_cycles = 0;
        while (!OutValid && mul_cycles < 40) begin
            idle(1);
            mul_cycles++;
        end
        check("mul_latency", mul_cycles, 16);
        check("mul_out", ALUOut, 16'h0000);
        check("mul_flags", FlagsOut, 4'b1100);

        // Drain mul result and accept an add on the same edge, then stall the consumer
        step(1, 16'h1234, 16'h1111, 5'b10100, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'hFFFF, 16'hFFFF, 5'b10100, 0, 1, 0);
            check("stall_out", ALUOut, 16'h2345);
        end
        step(1, 16'h0F0F, 16'h00FF, 5'b10111, 0, 1, 1);
        check("drain_accept_out", ALUOut, 16'h000F);

        step(1, 16'h8001, 16'h0000, 5'b11101, 0, 1, 1);
        check("asr_out", ALUOut, 16'hC000);
        check("asr_flags", FlagsOut, 4'b0100);

        // Reset during a multiply
        step(1, 16'h0003, 16'h0005, 5'b10000, 1, 1, 1);
        repeat (4) idle(1);
        Reset = 1'b0;
        #1;
        have_out  = 0;
        busy      = 0;
        flags_vis = '0;
        check("abort_out_valid", OutValid, 0);
        check("abort_flags", FlagsOut, 0);
        check("abort_alu_out", ALUOut, 0);
        idle(1);
        @(negedge Clock);
        Reset = 1'b1;
        step(1, 16'h0003, 16'h0005, 5'b00100, 0, 1, 1);
        check("post_abort_out", ALUOut, 16'h0008);
        check("post_abort_flags", FlagsOut, 4'b0000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 5'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0);
        end
        repeat (20) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
